alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one ALU datapath between NUM_REQ requesters.
- Arbitrates round-robin, with at most one operation outstanding.
- Drives the ALU input handshake (valid/ready, op, a, b) and collects the ALU output (done, result).
- Returns a one-cycle response pulse to the winning requester.
- Sits between requester logic and the ALU DUT; the alu_in and alu_out agents attach to its ALU-side ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_IN_OP_WIDTH, 8, width of operands a/b; result width is 2*ALU_IN_OP_WIDTH.
- TIMEOUT_CYCLES, 64, maximum cycles waiting for alu_done before error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted on the cycle req_valid[i]&req_ready[i].
- req_op  in  3*NUM_REQ  packed ops, requester i at [3i+2:3i].
- req_a, req_b  in  ALU_IN_OP_WIDTH*NUM_REQ  packed operands.
- rsp_valid  out  NUM_REQ  one-hot response pulse.
- rsp_result  out  2*ALU_IN_OP_WIDTH  result, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- alu_valid  out  1  ALU operation valid.
- alu_ready  in  1  ALU ready to accept.
- alu_op  out  3  op to ALU.
- alu_a, alu_b  out  ALU_IN_OP_WIDTH  operands to ALU.
- alu_done  in  1  ALU result valid (single-cycle pulse).
- alu_result  in  2*ALU_IN_OP_WIDTH  ALU result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; captured regs and timeout counter 0.
- Op codes:
  - 000 no_op; 001 add; 010 and; 011 xor; 100 mul.
  - 101..111 are reserved.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - req_ready is 0 when no request is valid.
  - On the accept edge: capture id/op/a/b, set rr_ptr <= (winner+1) mod NUM_REQ.
  - Next state: ISSUE for ops 001..100; RESP for no_op (result 0, err 0); RESP for reserved ops (result 0, err 1).
- ISSUE:
  - alu_valid=1 with captured op/a/b held stable until alu_ready.
  - On alu_valid&alu_ready: go to WAIT, clear the counter; alu_valid drops the next cycle.
  - alu_done in ISSUE is ignored.
- WAIT:
  - alu_valid=0; the counter increments each cycle.
  - On alu_done: register alu_result, err=0, go to RESP.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without done: result 0, err=1, go to RESP.
  - alu_done on the same edge as the timeout wins (err=0).
- RESP: rsp_valid[id]=1 for exactly one cycle with rsp_result/rsp_err; next state IDLE. rsp_result/rsp_err keep their value until the next RESP.
- Grant rules:
  - req_ready is 0 in every state except IDLE; requesters hold req_valid until accepted.
  - A requester receiving rsp_valid may re-request in the same cycle; it is granted the cycle after RESP, subject to rr_ptr.
- Latency:
  - no_op/reserved: accept edge to rsp_valid = 1 cycle.
  - ALU op with alu_ready=1 and done k cycles after the handshake: rsp_valid k+2 cycles after accept.
- rst_n low mid-operation: the outstanding op is dropped, no rsp_valid is produced, alu_valid deasserts immediately (async).
- The block performs no arithmetic; result width is passed through unchanged.

Test Plan:
- Single request: requester 2 sends add a=0x12 b=0x34; ALU ready and done 3 cycles later returning 0x0046 -> rsp_valid=4'b0100, rsp_result=0x0046, rsp_err=0, alu_op=001 seen once.
- Round-robin fairness: all 4 requesters hold mul a=i+1 b=2 -> grants in order 0,1,2,3, then 0 again, with exactly one alu_valid handshake per grant.
- Backpressure: alu_ready low for 5 cycles -> alu_valid stays high, alu_a/alu_b/alu_op stable; handshake on the 6th cycle; req_ready stays 0 throughout.
- no_op and reserved op: requester 1 sends op 000 -> rsp next cycle, result 0, err 0; op 110 -> err 1; alu_valid never asserted in either case.
- Timeout: TIMEOUT_CYCLES=8, ALU never asserts done -> rsp_err=1, rsp_result=0 exactly 8 cycles after the handshake; a done arriving later is ignored in IDLE.
- Reset mid-WAIT: assert rst_n=0 during WAIT -> busy=0, all outputs 0, rr_ptr=0, no rsp_valid; after release, requester 0 is granted first.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one ALU among NUM_REQ requesters, one
// operation in flight, with an optional watchdog on the ALU done pulse.
module alu_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ALU_IN_OP_WIDTH = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [3*NUM_REQ-1:0]               req_op,
  input  logic [ALU_IN_OP_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [ALU_IN_OP_WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [2*ALU_IN_OP_WIDTH-1:0]       rsp_result,
  output logic                               rsp_err,
  output logic                               alu_valid,
  input  logic                               alu_ready,
  output logic [2:0]                         alu_op,
  output logic [ALU_IN_OP_WIDTH-1:0]         alu_a,
  output logic [ALU_IN_OP_WIDTH-1:0]         alu_b,
  input  logic                               alu_done,
  input  logic [2*ALU_IN_OP_WIDTH-1:0]       alu_result,
  output logic                               busy
);
  localparam int W   = ALU_IN_OP_WIDTH;
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]      TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
  localparam logic [IDW-1:0]     LAST_ID = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q;
  logic [IDW-1:0]     rr_ptr_q, id_q;
  logic [2:0]         op_q;
  logic [W-1:0]       a_q, b_q;
  logic [CW-1:0]      cnt_q;
  logic [2*W-1:0]     res_q;
  logic               err_q, alu_valid_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  logic               found;
  logic [IDW-1:0]     win;
  logic [2:0]         win_op;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rr_idx(rr_ptr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_ptr_q, k);
      end
    end
  end

  assign win_op    = req_op[3*win +: 3];
  assign req_ready = (state_q == IDLE && found) ? (ONE << win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      alu_valid_q <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: if (found) begin
          id_q     <= win;
          op_q     <= win_op;
          a_q      <= req_a[W*win +: W];
          b_q      <= req_b[W*win +: W];
          rr_ptr_q <= (win == LAST_ID) ? '0 : win + IDW'(1);
          if (win_op != 3'd0 && win_op <= 3'd4) begin
            state_q     <= ISSUE;
            alu_valid_q <= 1'b1;
          end else begin
            // no_op completes cleanly; reserved codes complete with an error
            state_q     <= RESP;
            res_q       <= '0;
            err_q       <= (win_op != 3'd0);
            rsp_valid_q <= ONE << win;
          end
        end
        ISSUE: if (alu_ready) begin
          alu_valid_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // done is checked first so it beats a timeout on the same edge
          if (alu_done) begin
            res_q       <= alu_result;
            err_q       <= 1'b0;
            rsp_valid_q <= ONE << id_q;
            state_q     <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
            res_q       <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= ONE << id_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign alu_valid  = alu_valid_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Random requesters and a random ALU agent against a timeline model of when
// grants, ALU issues and responses must appear.
module tb_alu_req_arbiter;
  localparam int N = 4, W = 8, T = 8;

  logic             clk = 1'b0, rst_n;
  logic [N-1:0]     req_valid, req_ready, rsp_valid;
  logic [3*N-1:0]   req_op;
  logic [W*N-1:0]   req_a, req_b;
  logic [2*W-1:0]   rsp_result, alu_result;
  logic             rsp_err, alu_valid, alu_ready, alu_done, busy;
  logic [2:0]       alu_op;
  logic [W-1:0]     alu_a, alu_b;

  alu_req_arbiter #(.NUM_REQ(N), .ALU_IN_OP_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pending requests per requester
  bit         pv[N];
  logic [2:0] pop[N];
  logic [W-1:0] pa[N], pb[N];
  // transaction-level model
  int         cyc = 0, m_ptr = 0, m_id, m_h, rsp_due, done_at = -1;
  bit         m_active, m_aluop, m_hs, m_decided, burst = 0;
  logic [2:0] m_op;
  logic [W-1:0] m_a, m_b;
  logic [2*W-1:0] exp_res, last_res = '0;
  bit         exp_err, last_err = 0;

  task automatic step();
    logic [N-1:0] exp_rdy, exp_rsp;
    int w;
    bit exp_av, rsp_now;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!pv[i] && (burst || $urandom_range(0, 9) < 3)) begin
        int r;
        pv[i] = 1;
        r = $urandom_range(0, 9);
        pop[i] = (r < 6) ? 3'($urandom_range(1, 4)) : (r < 8) ? 3'd0 : 3'($urandom_range(5, 7));
        pa[i] = W'($urandom);
        pb[i] = W'($urandom);
      end
      req_valid[i]       = pv[i];
      req_op[3*i +: 3]   = pop[i];
      req_a[W*i +: W]    = pa[i];
      req_b[W*i +: W]    = pb[i];
    end
    alu_ready  = ($urandom_range(0, 3) != 0);
    alu_result = 16'($urandom);
    alu_done   = (cyc == done_at) ||
                 (!(m_active && m_hs && !m_decided) && $urandom_range(0, 15) == 0);
    #1;
    exp_rdy = '0; exp_rsp = '0; w = -1;
    if (!m_active)
      for (int k = 0; k < N; k++)
        if (w < 0 && pv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_av  = m_active && m_aluop && !m_hs;
    rsp_now = m_active && m_decided && (cyc == rsp_due);
    if (rsp_now) exp_rsp[m_id] = 1'b1;

    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_active));
    chk("alu_valid", 32'(alu_valid), 32'(exp_av));
    if (exp_av) begin
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    chk("rsp_result", 32'(rsp_result), rsp_now ? 32'(exp_res) : 32'(last_res));
    chk("rsp_err", 32'(rsp_err), rsp_now ? 32'(exp_err) : 32'(last_err));

    if (w >= 0) begin
      pv[w] = 0;
      m_active = 1; m_id = w; m_op = pop[w]; m_a = pa[w]; m_b = pb[w];
      m_ptr = (w + 1) % N;
      m_hs = 0;
      if (m_op >= 3'd1 && m_op <= 3'd4) begin
        m_aluop = 1; m_decided = 0;
      end else begin
        m_aluop = 0; m_decided = 1; rsp_due = cyc + 1;
        exp_res = '0; exp_err = (m_op != 3'd0);
      end
    end else if (exp_av && alu_ready) begin
      m_hs = 1; m_h = cyc;
      done_at = cyc + $urandom_range(1, 11);
    end else if (m_active && m_aluop && m_hs && !m_decided) begin
      if (alu_done) begin
        m_decided = 1; rsp_due = cyc + 1; exp_res = alu_result; exp_err = 0;
      end else if (cyc == m_h + T) begin
        m_decided = 1; rsp_due = cyc + 1; exp_res = '0; exp_err = 1;
      end
    end
    if (rsp_now) begin
      m_active = 0; last_res = exp_res; last_err = exp_err;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_alu_valid"}, 32'(alu_valid), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) pv[i] = 0;
    m_active = 0; m_hs = 0; m_decided = 0; m_aluop = 0; m_ptr = 0;
    last_res = '0; last_err = 0; done_at = -1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    alu_ready = 1'b0; alu_done = 1'b0; alu_result = '0;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    repeat (3000) step();

    // bring an ALU op into its wait-for-done window, then pull reset
    for (int n = 0; n < 300 && !(m_active && m_hs && !m_decided); n++) step();
    chk("reach_wait", 32'(m_active && m_hs && !m_decided), 32'd1);
    @(negedge clk);
    req_valid = '0; alu_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();

    // everyone requesting: grants must rotate 0,1,2,3,... starting at 0
    burst = 1;
    repeat (1000) step();
    burst = 0;
    repeat (500) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
